// File: rtl/chip8_mem_pkg.sv
// Shared constants for the chip-8 memory responder: request type codes,
// default address widths and the responder state encoding.
package chip8_mem_pkg;

    localparam logic VIDEO_MEM_TYPE_RAM  = 1'b0;
    localparam logic VIDEO_MEM_TYPE_VRAM = 1'b1;

    localparam int RAM_AW_DEFAULT  = 12;
    localparam int VRAM_AW_DEFAULT = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT
    } state_e;

endpackage

// File: rtl/chip8_mem_responder_if.sv
// Single-beat request/response bus between the video engine (master) and the
// memory responder (slave).
interface chip8_mem_responder_if;

    logic        req_valid;
    logic        req_we;
    logic        req_type;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    logic        req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;

    modport master (
        output req_valid, req_we, req_type, req_addr, req_data,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_data,
        output req_ready, resp_valid, resp_data
    );

endinterface

// File: rtl/chip8_mem_lat_pipe.sv
// Read-latency down-counter plus the registered response (valid pulse and data
// mux between the RAM and VRAM read ports).
module chip8_mem_lat_pipe #(
    parameter int BRAM_LATENCY = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       arm_i,
    input  logic       active_i,
    input  logic       sel_vram_i,
    input  logic       oor_i,
    input  logic [7:0] ram_data_i,
    input  logic [7:0] vram_data_i,
    output logic       fire_o,
    output logic       resp_valid_o,
    output logic [7:0] resp_data_o
);

    logic [2:0] cnt_q;
    logic       valid_q;
    logic [7:0] data_q;

    // The counter is loaded at accept, so it reaches zero exactly on the edge
    // where the BRAM read data is valid (enable cycle counts as cycle one).
    assign fire_o = active_i && (cnt_q == 3'd0);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt_q   <= 3'd0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            valid_q <= fire_o;
            if (arm_i) begin
                cnt_q <= 3'(BRAM_LATENCY - 1);
            end else if (active_i && (cnt_q != 3'd0)) begin
                cnt_q <= cnt_q - 3'd1;
            end
            if (fire_o) begin
                data_q <= oor_i ? 8'h00 : (sel_vram_i ? vram_data_i : ram_data_i);
            end
        end
    end

    assign resp_valid_o = valid_q;
    assign resp_data_o  = data_q;

endmodule

// File: rtl/chip8_mem_responder.sv
// Memory-side responder routing chip-8 requests to RAM or double-buffered VRAM.
// Optional CHIP8_MEM_ERR_EN adds a sticky out-of-range flag and first bad address.
module chip8_mem_responder
    import chip8_mem_pkg::*;
#(
    parameter int RAM_AW       = RAM_AW_DEFAULT,
    parameter int VRAM_AW      = VRAM_AW_DEFAULT,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 ad_in,
    chip8_mem_responder_if.slave bus,
    output logic                 ram_en_out,
    output logic                 ram_we_out,
    output logic [RAM_AW-1:0]    ram_addr_out,
    output logic [7:0]           ram_data_out,
    input  logic [7:0]           ram_data_in,
    output logic                 vram_en_out,
    output logic                 vram_we_out,
    output logic [VRAM_AW:0]     vram_addr_out,
    output logic [7:0]           vram_data_out,
    input  logic [7:0]           vram_data_in
`ifdef CHIP8_MEM_ERR_EN
    ,
    output logic                 err_out,
    output logic [15:0]          err_addr_out
`endif
);

    state_e state_q, state_d;
    logic   we_q, vram_q, oor_q;
    logic   accept, req_oor, fire, pipe_active;
    logic   resp_valid;
    logic [7:0] resp_data;

    logic              ram_en_q, ram_we_q, vram_en_q, vram_we_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [VRAM_AW:0]  vram_addr_q;
    logic [7:0]        ram_data_q, vram_data_q;

    assign accept  = (state_q == IDLE) && bus.req_valid;
    assign req_oor = (bus.req_type == VIDEO_MEM_TYPE_VRAM)
                   ? ((bus.req_addr >> VRAM_AW) != 16'd0)
                   : ((bus.req_addr >> RAM_AW) != 16'd0);
    assign pipe_active = ((state_q == ISSUE) || (state_q == WAIT)) && !we_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = (we_q || fire) ? IDLE : WAIT;
            WAIT:    if (fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // BRAM controls are loaded on the accept edge so the enable appears for
    // exactly the one ISSUE cycle; out-of-range requests never enable a port.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            vram_q      <= 1'b0;
            oor_q       <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= 8'h00;
            vram_en_q   <= 1'b0;
            vram_we_q   <= 1'b0;
            vram_addr_q <= '0;
            vram_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            ram_en_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            vram_en_q <= 1'b0;
            vram_we_q <= 1'b0;
            if (accept) begin
                we_q   <= bus.req_we;
                vram_q <= bus.req_type;
                oor_q  <= req_oor;
                if (!req_oor) begin
                    if (bus.req_type == VIDEO_MEM_TYPE_VRAM) begin
                        vram_en_q   <= 1'b1;
                        vram_we_q   <= bus.req_we;
                        vram_addr_q <= {ad_in, bus.req_addr[VRAM_AW-1:0]};
                        vram_data_q <= bus.req_data;
                    end else begin
                        ram_en_q   <= 1'b1;
                        ram_we_q   <= bus.req_we;
                        ram_addr_q <= bus.req_addr[RAM_AW-1:0];
                        ram_data_q <= bus.req_data;
                    end
                end
            end
        end
    end

    chip8_mem_lat_pipe #(
        .BRAM_LATENCY(BRAM_LATENCY)
    ) u_lat_pipe (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .arm_i        (accept),
        .active_i     (pipe_active),
        .sel_vram_i   (vram_q),
        .oor_i        (oor_q),
        .ram_data_i   (ram_data_in),
        .vram_data_i  (vram_data_in),
        .fire_o       (fire),
        .resp_valid_o (resp_valid),
        .resp_data_o  (resp_data)
    );

`ifdef CHIP8_MEM_ERR_EN
    logic        err_q;
    logic [15:0] err_addr_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_q      <= 1'b0;
            err_addr_q <= 16'h0000;
        end else if (accept && req_oor) begin
            err_q <= 1'b1;
            if (!err_q) err_addr_q <= bus.req_addr;
        end
    end

    assign err_out      = err_q;
    assign err_addr_out = err_addr_q;
`endif

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid;
    assign bus.resp_data  = resp_data;

    assign ram_en_out    = ram_en_q;
    assign ram_we_out    = ram_we_q;
    assign ram_addr_out  = ram_addr_q;
    assign ram_data_out  = ram_data_q;
    assign vram_en_out   = vram_en_q;
    assign vram_we_out   = vram_we_q;
    assign vram_addr_out = vram_addr_q;
    assign vram_data_out = vram_data_q;

endmodule

// File: tb/tb_chip8_mem_responder.sv
// Bench for chip8_mem_responder: BRAM models, a request-level timing/data model
// checked every cycle, and directed vectors with literal expectations.
module tb_chip8_mem_responder;

    localparam int RAM_AW  = 12;
    localparam int VRAM_AW = 8;
    localparam int LAT     = 2;

    logic clk_in = 1'b0;
    logic rst_in;
    logic ad_in;
    always #5 clk_in = ~clk_in;

    chip8_mem_responder_if bus();

    logic              ramEn, ramWe, vramEn, vramWe;
    logic [RAM_AW-1:0] ramAddr;
    logic [VRAM_AW:0]  vramAddr;
    logic [7:0]        ramWdata, vramWdata;
    logic [7:0]        ramRd = 8'h00;
    logic [7:0]        vramRd = 8'h00;
`ifdef CHIP8_MEM_ERR_EN
    logic              errOut;
    logic [15:0]       errAddrOut;
`endif

    chip8_mem_responder #(
        .RAM_AW(RAM_AW), .VRAM_AW(VRAM_AW), .BRAM_LATENCY(LAT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .ad_in(ad_in), .bus(bus),
        .ram_en_out(ramEn), .ram_we_out(ramWe), .ram_addr_out(ramAddr),
        .ram_data_out(ramWdata), .ram_data_in(ramRd),
        .vram_en_out(vramEn), .vram_we_out(vramWe), .vram_addr_out(vramAddr),
        .vram_data_out(vramWdata), .vram_data_in(vramRd)
`ifdef CHIP8_MEM_ERR_EN
        , .err_out(errOut), .err_addr_out(errAddrOut)
`endif
    );

    // Synchronous BRAMs: data appears the cycle after the enable cycle.
    logic [7:0] ramMem [4096];
    logic [7:0] vramMem [512];
    always @(posedge clk_in) begin
        if (ramEn) begin
            if (ramWe) ramMem[ramAddr] <= ramWdata;
            else       ramRd <= ramMem[ramAddr];
        end
        if (vramEn) begin
            if (vramWe) vramMem[vramAddr] <= vramWdata;
            else        vramRd <= vramMem[vramAddr];
        end
    end

    int checkCount = 0;
    int errorCount = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: cycle k is the period ending at posedge k.
    int   cyc = 0;
    logic started = 1'b0;
    int   readyFromEdge = 0;
    int   enCycle = -1;
    logic enVram, enWe;
    int   enAddr;
    logic [7:0] enData;
    int   respCycle = -1;
    logic [7:0] respData;
    logic [7:0] shRam [4096];
    logic [7:0] shVram [512];

    always @(posedge clk_in) begin
        logic isV, oor;
        int   lin;
        cyc = cyc + 1;
        if (rst_in) begin
            started = 1'b1;
            readyFromEdge = cyc + 1;
            enCycle = -1;
            respCycle = -1;
        end else if (started && bus.req_valid && cyc >= readyFromEdge) begin
            isV = bus.req_type;
            oor = isV ? (int'(bus.req_addr) >= (1 << VRAM_AW)) : (int'(bus.req_addr) >= (1 << RAM_AW));
            lin = isV ? (int'(ad_in) * 256 + int'(bus.req_addr[7:0])) : int'(bus.req_addr[11:0]);
            enCycle = oor ? -1 : cyc + 1;
            enVram = isV;
            enWe = bus.req_we;
            enAddr = lin;
            enData = bus.req_data;
            if (bus.req_we) begin
                readyFromEdge = cyc + 2;
                respCycle = -1;
                if (!oor) begin
                    if (isV) shVram[lin] = bus.req_data;
                    else     shRam[lin] = bus.req_data;
                end
            end else begin
                readyFromEdge = cyc + 1 + LAT;
                respCycle = cyc + 1 + LAT;
                respData = oor ? 8'h00 : (isV ? shVram[lin] : shRam[lin]);
            end
        end
    end

    // Compare process: every cycle once the first reset edge has been seen.
    always @(negedge clk_in) begin
        int c;
        c = cyc + 1;
        if (started) begin
            checkOutput("ready", 32'(bus.req_ready), 32'(c >= readyFromEdge));
            checkOutput("resp_valid", 32'(bus.resp_valid), 32'(c == respCycle));
            if (c == respCycle) checkOutput("resp_data", 32'(bus.resp_data), 32'(respData));
            checkOutput("ram_en", 32'(ramEn), 32'(c == enCycle && !enVram));
            checkOutput("ram_we", 32'(ramWe), 32'(c == enCycle && !enVram && enWe));
            checkOutput("vram_en", 32'(vramEn), 32'(c == enCycle && enVram));
            checkOutput("vram_we", 32'(vramWe), 32'(c == enCycle && enVram && enWe));
            if (c == enCycle && enVram) begin
                checkOutput("vram_addr", 32'(vramAddr), 32'(enAddr));
                if (enWe) checkOutput("vram_wdata", 32'(vramWdata), 32'(enData));
            end
            if (c == enCycle && !enVram) begin
                checkOutput("ram_addr", 32'(ramAddr), 32'(enAddr));
                if (enWe) checkOutput("ram_wdata", 32'(ramWdata), 32'(enData));
            end
        end
    end

    // Waits (bounded) for ready at a negedge, drives one request cycle, and
    // returns at the negedge of the cycle after the accept edge.
    task automatic applyStimulus(input logic we, input logic typ, input logic [15:0] addr,
                                 input logic [7:0] data, input logic ad);
        int waitCnt = 0;
        while (bus.req_ready !== 1'b1 && waitCnt < 20) begin
            @(negedge clk_in);
            waitCnt++;
        end
        if (bus.req_ready !== 1'b1) begin
            checkCount++;
            errorCount++;
            $display("[TB] FAIL ready_timeout: got 0x%0h expected 0x1", bus.req_ready);
        end
        ad_in = ad;
        bus.req_valid = 1'b1;
        bus.req_we = we;
        bus.req_type = typ;
        bus.req_addr = addr;
        bus.req_data = data;
        @(negedge clk_in);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int enCount;
        for (int i = 0; i < 4096; i++) begin
            ramMem[i] = 8'h00;
            shRam[i] = 8'h00;
        end
        for (int i = 0; i < 512; i++) begin
            vramMem[i] = 8'h00;
            shVram[i] = 8'h00;
        end
        ramMem[12'h200] = 8'hF0;
        shRam[12'h200] = 8'hF0;

        rst_in = 1'b1;
        ad_in = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we = 1'b0;
        bus.req_type = 1'b0;
        bus.req_addr = 16'h0000;
        bus.req_data = 8'h00;
        repeat (3) @(negedge clk_in);
        checkOutput("rst_ready", 32'(bus.req_ready), 32'h1);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        checkOutput("rst_resp_data", 32'(bus.resp_data), 32'h0);
        checkOutput("rst_ram_addr", 32'(ramAddr), 32'h0);
        checkOutput("rst_vram_addr", 32'(vramAddr), 32'h0);
        rst_in = 1'b0;
        @(negedge clk_in);

        $display("[TB] VRAM write 0x0012 <= 0xA5, buffer 0");
        applyStimulus(1'b1, 1'b1, 16'h0012, 8'hA5, 1'b0);
        checkOutput("wr_vram_en", 32'(vramEn), 32'h1);
        checkOutput("wr_vram_we", 32'(vramWe), 32'h1);
        checkOutput("wr_vram_addr", 32'(vramAddr), 32'h012);
        checkOutput("wr_ready_busy", 32'(bus.req_ready), 32'h0);
        @(negedge clk_in);
        checkOutput("wr_ready_back", 32'(bus.req_ready), 32'h1);

        $display("[TB] VRAM read-back, ad_in toggled mid-flight");
        applyStimulus(1'b0, 1'b1, 16'h0012, 8'h00, 1'b0);
        ad_in = 1'b1;
        @(negedge clk_in);
        checkOutput("rd_early_valid", 32'(bus.resp_valid), 32'h0);
        @(negedge clk_in);
        checkOutput("rd_valid", 32'(bus.resp_valid), 32'h1);
        checkOutput("rd_data", 32'(bus.resp_data), 32'hA5);
        checkOutput("rd_ready", 32'(bus.req_ready), 32'h1);

        $display("[TB] VRAM read, buffer 1");
        applyStimulus(1'b0, 1'b1, 16'h0012, 8'h00, 1'b1);
        checkOutput("buf1_addr", 32'(vramAddr), 32'h112);
        repeat (2) @(negedge clk_in);
        checkOutput("buf1_data", 32'(bus.resp_data), 32'h00);

        $display("[TB] RAM read 0x0200");
        applyStimulus(1'b0, 1'b0, 16'h0200, 8'h00, 1'b0);
        checkOutput("ram_rd_addr", 32'(ramAddr), 32'h200);
        repeat (2) @(negedge clk_in);
        checkOutput("ram_rd_data", 32'(bus.resp_data), 32'hF0);

        $display("[TB] out-of-range accesses");
        applyStimulus(1'b1, 1'b1, 16'h0100, 8'h77, 1'b0);
        checkOutput("oor_wr_vram_en", 32'(vramEn), 32'h0);
        @(negedge clk_in);
        applyStimulus(1'b0, 1'b1, 16'h0100, 8'h00, 1'b0);
        checkOutput("oor_rd_vram_en", 32'(vramEn), 32'h0);
        repeat (2) @(negedge clk_in);
        checkOutput("oor_rd_valid", 32'(bus.resp_valid), 32'h1);
        checkOutput("oor_rd_data", 32'(bus.resp_data), 32'h00);
        applyStimulus(1'b0, 1'b0, 16'h1000, 8'h00, 1'b0);
        checkOutput("oor_rd_ram_en", 32'(ramEn), 32'h0);
        repeat (2) @(negedge clk_in);
        checkOutput("oor_ram_data", 32'(bus.resp_data), 32'h00);
`ifdef CHIP8_MEM_ERR_EN
        checkOutput("err_flag", 32'(errOut), 32'h1);
        checkOutput("err_addr", 32'(errAddrOut), 32'h0100);
`endif

        $display("[TB] req_valid held for 6 cycles");
        ad_in = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_we = 1'b1;
        bus.req_type = 1'b0;
        bus.req_addr = 16'h0300;
        bus.req_data = 8'h3C;
        enCount = 0;
        repeat (6) begin
            @(negedge clk_in);
            if (ramEn === 1'b1) enCount++;
        end
        bus.req_valid = 1'b0;
        checkOutput("b2b_accepts", 32'(enCount), 32'd3);
        applyStimulus(1'b0, 1'b0, 16'h0300, 8'h00, 1'b0);
        repeat (2) @(negedge clk_in);
        checkOutput("b2b_readback", 32'(bus.resp_data), 32'h3C);

        $display("[TB] reset during WAIT");
        applyStimulus(1'b0, 1'b0, 16'h0200, 8'h00, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        checkOutput("rst_mid_valid", 32'(bus.resp_valid), 32'h0);
        checkOutput("rst_mid_ready", 32'(bus.req_ready), 32'h1);
        repeat (3) @(negedge clk_in);
        applyStimulus(1'b0, 1'b0, 16'h0200, 8'h00, 1'b0);
        repeat (2) @(negedge clk_in);
        checkOutput("post_rst_valid", 32'(bus.resp_valid), 32'h1);
        checkOutput("post_rst_data", 32'(bus.resp_data), 32'hF0);

        repeat (3) @(negedge clk_in);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/chip8_mem_responder.md
Name: chip8_mem_responder

Overview:
- Memory-side responder for the chip-8 memory request interface.
- Accepts single-beat read/write requests from one initiator (the per-core video engine), typed RAM (sprite/program) or VRAM (framebuffer).
- Routes each request to the matching BRAM port and returns read data with a one-cycle valid pulse.
- Owns VRAM double-buffer selection: the buffer index is sampled when a request is accepted.

Parameters:
- RAM_AW, 12, RAM BRAM address width (4 KiB).
- VRAM_AW, 8, address width of one VRAM buffer (8 bytes x 32 rows = 256 bytes).
- BRAM_LATENCY, 2, cycles from the BRAM enable cycle to valid BRAM read data (1..4).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous reset, active-high
- ad_in  in  1  VRAM buffer select; sampled at request accept
- req_valid_in  in  1  request strobe, single cycle
- req_we_in  in  1  1 = write, 0 = read
- req_type_in  in  1  0 = RAM, 1 = VRAM (VIDEO_MEM_TYPE_*)
- req_addr_in  in  16  byte address
- req_data_in  in  8  write data
- req_ready_out  out  1  responder can accept a request this cycle
- resp_valid_out  out  1  read data valid, one-cycle pulse
- resp_data_out  out  8  read data
- ram_en_out / ram_we_out  out  1 / 1  RAM BRAM enable / write enable
- ram_addr_out  out  RAM_AW  RAM BRAM address
- ram_data_out  out  8  RAM BRAM write data
- ram_data_in  in  8  RAM BRAM read data
- vram_en_out / vram_we_out  out  1 / 1  VRAM BRAM enable / write enable
- vram_addr_out  out  VRAM_AW+1  VRAM BRAM address; MSB is the buffer bit
- vram_data_out  out  8  VRAM BRAM write data
- vram_data_in  in  8  VRAM BRAM read data

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - Reset forces IDLE and zeroes resp_valid_out, resp_data_out, all en/we/addr/data outputs and the latency counter.
  - req_ready_out = (state == IDLE), so it is 1 from the first edge with rst_in high.
- States:
  - IDLE: req_ready_out=1. On req_valid_in=1, capture we/type/addr/data and buf = ad_in, then go to ISSUE. Requests arriving outside IDLE are ignored, not queued.
  - ISSUE, 1 cycle: the selected port's en_out is 1, we_out = captured we, addr and data registered. Write → IDLE. Read → WAIT, counter = BRAM_LATENCY-1.
  - WAIT: count down; at 0, resp_data_out <= selected port's data_in, resp_valid_out=1 for one cycle, go to IDLE.
- Timing, with request accepted at edge N:
  - BRAM en is high in cycle N+1.
  - Write: ready returns in cycle N+2.
  - Read: resp_valid is high in cycle N+1+BRAM_LATENCY, and ready is high in that same cycle.
- Address mapping:
  - RAM: ram_addr = addr[RAM_AW-1:0].
  - VRAM: vram_addr = {buf, addr[VRAM_AW-1:0]}.
- Out-of-range access (RAM with addr[15:RAM_AW] != 0, or VRAM with addr[15:VRAM_AW] != 0):
  - No port enable is driven.
  - A read returns 0x00 with identical timing.
  - A write is dropped with identical timing.
- ad_in changing mid-transaction has no effect on the in-flight request.
- Reset mid-read: the pending response is discarded; no resp_valid pulse follows reset.
- The port not selected keeps en=0 and we=0 every cycle.

Optional Feature:
- Macro: CHIP8_MEM_ERR_EN.
- Defined:
  - Adds output err_out (1 bit), a sticky flag set in the ISSUE cycle of any out-of-range access and cleared only by reset.
  - Adds output err_addr_out (16 bits), holding the first offending address.
- Undefined: neither port exists, and out-of-range accesses are silently handled as above.

Decomposition:
- chip8_mem_pkg holds:
  - VIDEO_MEM_TYPE_RAM = 1'b0 and VIDEO_MEM_TYPE_VRAM = 1'b1.
  - Default RAM_AW and VRAM_AW constants.
  - The state enum {IDLE, ISSUE, WAIT}.
- One sub-module, chip8_mem_lat_pipe: parameterised BRAM_LATENCY down-counter and response-select register.

Test Plan:
- VRAM write: ad_in=0, write type=1 addr=0x0012 data=0xA5 → vram_en/we=1, vram_addr=0x012 in cycle N+1; ready=1 in cycle N+2.
- Read-back: read type=1 addr=0x0012 with ad_in=0 → resp_valid in cycle N+3 (BRAM_LATENCY=2), data 0xA5; the same read with ad_in=1 → data 0x00 from buffer 1 (addr 0x112).
- RAM read: type=0 addr=0x0200 with model byte 0xF0 → ram_addr=0x200; resp_data=0xF0; vram_en stays 0 throughout.
- Out-of-range: VRAM write addr=0x0100, then read addr=0x0100 → no en pulse; read returns 0x00 on schedule; with CHIP8_MEM_ERR_EN defined, err_out=1 and err_addr_out=0x0100.
- Back-to-back: req_valid held high for 6 cycles → exactly one accept per IDLE window, and no request is accepted while ready=0.
- Reset mid-read: assert rst_in in the WAIT cycle → no resp_valid afterwards; ready=1 after the reset edge; a following read completes normally.
